// File: rtl/alu_pkg.sv
// Shared opcode encoding and instruction-width helpers for the ALU/register-file pipeline.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDI = 4'h1,
        OP_MOV = 4'h2,
        OP_ADD = 4'h3,
        OP_SUB = 4'h4,
        OP_AND = 4'h5,
        OP_OR  = 4'h6,
        OP_XOR = 4'h7,
        OP_NOT = 4'h8,
        OP_SHL = 4'h9,
        OP_SHR = 4'hA,
        OP_ADC = 4'hB,
        OP_OUT = 4'hC
    } op_e;

    localparam int unsigned OPW = 4;

    function automatic int unsigned addr_width(input int unsigned nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

    function automatic int unsigned instr_width(input int unsigned nreg);
        return OPW + 3 * addr_width(nreg);
    endfunction

    // Opcodes that write a destination register (LDI..ADC).
    function automatic logic writes_reg(input logic [3:0] op);
        return (op >= OP_LDI) && (op <= OP_ADC);
    endfunction

    // Opcodes that update zero/carry (ADD..ADC).
    function automatic logic updates_flags(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_ADC);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: operation select, result, carry-out and zero detect.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] imm,
    input  logic         carry_in,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         zero
);

    logic [W:0] sum;

    always_comb begin
        sum    = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_LDI: result = imm;
            OP_MOV: result = a;
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[W-1:0];
                carry  = sum[W];
            end
            OP_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result = {a[W-2:0], 1'b0};
                carry  = a[W-1];
            end
            OP_SHR: begin
                result = {1'b0, a[W-1:1]};
                carry  = a[0];
            end
            OP_ADC: begin
                sum    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_in};
                result = sum[W-1:0];
                carry  = sum[W];
            end
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_regfile_pipe.sv
// Two-stage ALU pipeline: S1 captures instruction and operands (with S2 bypass),
// S2 executes and writes back registers, flags and the output port.
module alu_regfile_pipe
    import alu_pkg::*;
#(
    parameter  int unsigned W    = 8,
    parameter  int unsigned NREG = 4,
    localparam int unsigned AW   = addr_width(NREG),
    localparam int unsigned IW   = instr_width(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    input  logic [IW-1:0] instr,
    input  logic [W-1:0]  data_in,
    output logic [W-1:0]  data_out,
    output logic          out_valid,
    output logic          zero_flag,
    output logic          carry_flag
);

    logic [W-1:0]  rf [NREG];

    logic          s1_valid;
    logic [3:0]    s1_op;
    logic [AW-1:0] s1_dst;
    logic [W-1:0]  s1_a;
    logic [W-1:0]  s1_b;
    logic [W-1:0]  s1_imm;

    logic [3:0]    in_op_c;
    logic [AW-1:0] in_dst_c;
    logic [AW-1:0] in_srca_c;
    logic [AW-1:0] in_srcb_c;
    logic [W-1:0]  opa_c;
    logic [W-1:0]  opb_c;

    logic [W-1:0]  alu_result_c;
    logic          alu_carry_c;
    logic          alu_zero_c;
    logic          wr_en_c;
    logic          flag_en_c;
    logic          out_en_c;

    assign in_op_c   = instr[IW-1 -: 4];
    assign in_dst_c  = instr[3*AW-1 -: AW];
    assign in_srca_c = instr[2*AW-1 -: AW];
    assign in_srcb_c = instr[AW-1:0];

    assign wr_en_c   = s1_valid && writes_reg(s1_op);
    assign flag_en_c = s1_valid && updates_flags(s1_op);
    assign out_en_c  = s1_valid && (s1_op == OP_OUT);

    // Forward the S2 write-back value into operand capture for back-to-back dependencies.
    assign opa_c = (wr_en_c && (in_srca_c == s1_dst)) ? alu_result_c : rf[in_srca_c];
    assign opb_c = (wr_en_c && (in_srcb_c == s1_dst)) ? alu_result_c : rf[in_srcb_c];

    alu_core #(.W(W)) u_alu (
        .op       (s1_op),
        .a        (s1_a),
        .b        (s1_b),
        .imm      (s1_imm),
        .carry_in (carry_flag),
        .result   (alu_result_c),
        .carry    (alu_carry_c),
        .zero     (alu_zero_c)
    );

    // Reset takes priority so an in-flight S1 instruction never writes back.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                rf[i] <= '0;
            end
            s1_valid   <= 1'b0;
            s1_op      <= '0;
            s1_dst     <= '0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_imm     <= '0;
            data_out   <= '0;
            out_valid  <= 1'b0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
        end else begin
            s1_valid <= instr_valid;
            if (instr_valid) begin
                s1_op  <= in_op_c;
                s1_dst <= in_dst_c;
                s1_a   <= opa_c;
                s1_b   <= opb_c;
                s1_imm <= data_in;
            end
            if (wr_en_c) begin
                rf[s1_dst] <= alu_result_c;
            end
            if (flag_en_c) begin
                zero_flag  <= alu_zero_c;
                carry_flag <= alu_carry_c;
            end
            out_valid <= out_en_c;
            if (out_en_c) begin
                data_out <= s1_a;
            end
        end
    end

endmodule
